decode_operand_stage: RTL and testbench
=======================================

Name: decode_operand_stage

Overview:
- Decode-side stage directly downstream of the register file.
- Consumes the three register-file read ports (D_src_0/1/2_data) and the writeback bus (MW_insn_dst, MW_insn_is_F1/F2, W_result).
- Tracks in-flight register writes with a per-register scoreboard and stalls the fetch/decode latch on RAW hazards.
- Latches resolved operands into the D->X pipeline register with a valid/ready handshake.

Parameters:
- DATA_W, 8, register data width; equals the register file entry width.
- REG_CNT, 16, number of architectural registers.
- PTR_W, 4, register pointer width; log2(REG_CNT).
- PEND_W, 2, width of each per-register pending-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- FD_valid  in  1  the FD latch holds an instruction.
- FD_insn_src_0/1/2  in  PTR_W each  source register pointers; also drive the register-file read addresses.
- FD_src_used  in  3  bit i=1 means src_i is a real operand.
- FD_insn_dst  in  PTR_W  destination register pointer.
- FD_insn_writes  in  1  the instruction writes FD_insn_dst (F1/F2 class).
- D_src_0/1/2_data  in  DATA_W each  register-file read data.
- MW_insn_dst  in  PTR_W  writeback destination.
- MW_insn_is_F1, MW_insn_is_F2  in  1 each  writeback is valid when either is set.
- W_result  in  DATA_W  writeback data.
- DX_ready  in  1  the X stage accepts the DX register this cycle.
- FD_stall  out  1  combinational; holds the FD latch.
- DX_valid  out  1  the DX register holds an instruction.
- DX_src_0/1/2_data  out  DATA_W each  latched operands.
- DX_insn_dst  out  PTR_W  latched destination.
- DX_insn_writes  out  1  latched write flag.

Behaviour:
- Reset (asynchronous, active-high):
  - DX_valid, DX_insn_writes = 0.
  - All DX data and dst outputs = 0.
  - All pending counters = 0.
  - FD_stall is combinational: it is 0 whenever FD_valid=0.
- Writeback event:
  - wb = MW_insn_is_F1 | MW_insn_is_F2.
  - wb_hit_i = wb & (MW_insn_dst == FD_insn_src_i).
- Operand hazard for src_i (FD_src_used[i]=1), with pend = counter[src_i]:
  - pend==0: no hazard.
  - pend==1 and wb_hit_i: resolved by bypass (see Optional Feature).
  - Otherwise: hazard.
- Capacity hazard: FD_insn_writes=1 and counter[FD_insn_dst] equals all-ones and no wb to that register this cycle.
- Downstream free: dx_free = !DX_valid | DX_ready.
- Issue and stall:
  - issue = FD_valid & !any_hazard & dx_free.
  - FD_stall = FD_valid & !issue.
- On issue, at the next edge:
  - DX_valid <= 1.
  - Capture dst and writes.
  - Capture operands: W_result when bypass is selected, else D_src_i_data.
  - Unused operands are captured as 0.
- No issue and DX_ready=1: DX_valid <= 0.
- No issue and DX_ready=0: DX register holds all its values.
- Latency: one cycle from FD to DX when there is no hazard. Back-to-back issue at one instruction per cycle is allowed.
- Counter update per register r, evaluated each edge:
  - inc = issue & FD_insn_writes & (FD_insn_dst==r).
  - dec = wb & (MW_insn_dst==r) & (counter[r] != 0).
  - inc & dec: counter unchanged.
  - inc only: counter+1. Never overflows, because the capacity hazard blocks issue at all-ones.
  - dec only: counter-1.
  - A writeback to a register whose counter is 0 is ignored; the counter stays 0. This covers R0 initialisation writes.
- Pipeline hold: when DX_ready=0 and DX_valid=1, no issue occurs and counters change only by dec.
- Reset mid-operation clears all state immediately. In-flight writebacks that arrive afterwards hit counter 0 and are ignored.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: in the pend==1 & wb_hit_i case the operand is W_result, with no stall.
- Undefined: that case is a hazard, so FD_stall=1 for one cycle. The next cycle the register file holds the new value and the instruction issues. No path from W_result to DX data exists in this build.

Test Plan:
- Reset, then FD_valid=1, src0=R3 used, D_src_0_data=0x5A, DX_ready=1 -> FD_stall=0; next cycle DX_valid=1, DX_src_0_data=0x5A.
- Issue a write to R2 (counter 0->1), then a reader of R2 with no writeback -> FD_stall=1 each cycle. Writeback R2 with W_result=0x33 -> with bypass: issue that cycle, DX_src_0_data=0x33, counter 0. Without bypass: one extra stall cycle, then the register-file value is used.
- Issue three writes to R5 with no writebacks -> counter=3. A fourth writer of R5 -> FD_stall=1 until a writeback of R5 arrives in the same cycle, after which the counter stays 3.
- Same-cycle issue-write R7 and writeback R7 with counter=1 -> counter remains 1.
- DX_valid=1, DX_ready=0 for 3 cycles with FD_valid=1 -> FD_stall=1 and DX outputs stable; DX_ready=1 -> the new instruction is captured next cycle.
- Writeback to R0 with counter 0 -> counter stays 0. Assert reset mid-stream with counters nonzero -> DX_valid=0 and all counters 0 immediately.

Source files
------------

// File: rtl/decode_operand_stage_if.sv
// Decode/operand stage bus: FD latch fields, register-file read data,
// writeback bus and the D->X pipeline register outputs.
// The master side drives the FD/writeback/read-data/DX_ready signals.
// The slave side is the decode_operand_stage itself.
interface decode_operand_stage_if #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 4
);
    logic              FD_valid;
    logic [PTR_W-1:0]  FD_insn_src_0;
    logic [PTR_W-1:0]  FD_insn_src_1;
    logic [PTR_W-1:0]  FD_insn_src_2;
    logic [2:0]        FD_src_used;
    logic [PTR_W-1:0]  FD_insn_dst;
    logic              FD_insn_writes;
    logic [DATA_W-1:0] D_src_0_data;
    logic [DATA_W-1:0] D_src_1_data;
    logic [DATA_W-1:0] D_src_2_data;
    logic [PTR_W-1:0]  MW_insn_dst;
    logic              MW_insn_is_F1;
    logic              MW_insn_is_F2;
    logic [DATA_W-1:0] W_result;
    logic              DX_ready;
    logic              FD_stall;
    logic              DX_valid;
    logic [DATA_W-1:0] DX_src_0_data;
    logic [DATA_W-1:0] DX_src_1_data;
    logic [DATA_W-1:0] DX_src_2_data;
    logic [PTR_W-1:0]  DX_insn_dst;
    logic              DX_insn_writes;

    modport master (
        output FD_valid, FD_insn_src_0, FD_insn_src_1, FD_insn_src_2,
        output FD_src_used, FD_insn_dst, FD_insn_writes,
        output D_src_0_data, D_src_1_data, D_src_2_data,
        output MW_insn_dst, MW_insn_is_F1, MW_insn_is_F2, W_result,
        output DX_ready,
        input  FD_stall, DX_valid, DX_src_0_data, DX_src_1_data, DX_src_2_data,
        input  DX_insn_dst, DX_insn_writes
    );

    modport slave (
        input  FD_valid, FD_insn_src_0, FD_insn_src_1, FD_insn_src_2,
        input  FD_src_used, FD_insn_dst, FD_insn_writes,
        input  D_src_0_data, D_src_1_data, D_src_2_data,
        input  MW_insn_dst, MW_insn_is_F1, MW_insn_is_F2, W_result,
        input  DX_ready,
        output FD_stall, DX_valid, DX_src_0_data, DX_src_1_data, DX_src_2_data,
        output DX_insn_dst, DX_insn_writes
    );
endinterface

// File: rtl/decode_operand_stage.sv
// Decode operand stage: per-register pending-write scoreboard, RAW and
// scoreboard-capacity stall generation, and the D->X pipeline register.
// Optional build macro DECODE_BYPASS_EN: when defined, an operand whose only
// outstanding write is arriving on the writeback bus this cycle is taken
// from W_result instead of stalling. When undefined, that case stalls one
// cycle and the register file supplies the value on the following cycle.
module decode_operand_stage #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 16,
    parameter int PTR_W   = 4,
    parameter int PEND_W  = 2
) (
    input logic                  clk,
    input logic                  reset,
    decode_operand_stage_if.slave bus
);

    logic [PEND_W-1:0] pend_q [REG_CNT];
    logic [PEND_W-1:0] pend_d [REG_CNT];

    logic              dx_valid_q, dx_valid_d;
    logic              dx_writes_q, dx_writes_d;
    logic [PTR_W-1:0]  dx_dst_q, dx_dst_d;
    logic [DATA_W-1:0] dx_src_q [3];
    logic [DATA_W-1:0] dx_src_d [3];

    logic [PTR_W-1:0]  src_ptr [3];
    logic [DATA_W-1:0] src_data [3];
    logic [DATA_W-1:0] opnd [3];
    logic [2:0]        wb_hit;
    logic [2:0]        src_haz;
`ifdef DECODE_BYPASS_EN
    logic [2:0]        byp_sel;
`endif
    logic              wb;
    logic              cap_haz;
    logic              dx_free;
    logic              issue;

    assign src_ptr[0]  = bus.FD_insn_src_0;
    assign src_ptr[1]  = bus.FD_insn_src_1;
    assign src_ptr[2]  = bus.FD_insn_src_2;
    assign src_data[0] = bus.D_src_0_data;
    assign src_data[1] = bus.D_src_1_data;
    assign src_data[2] = bus.D_src_2_data;

    // Hazard detection, issue decision and operand selection.
    always_comb begin
        wb      = bus.MW_insn_is_F1 | bus.MW_insn_is_F2;
        wb_hit  = '0;
        src_haz = '0;
`ifdef DECODE_BYPASS_EN
        byp_sel = '0;
`endif
        for (int i = 0; i < 3; i++) begin
            wb_hit[i] = wb && (bus.MW_insn_dst == src_ptr[i]);
            if (bus.FD_src_used[i] && (pend_q[src_ptr[i]] != '0)) begin
                if ((pend_q[src_ptr[i]] == PEND_W'(1)) && wb_hit[i]) begin
`ifdef DECODE_BYPASS_EN
                    byp_sel[i] = 1'b1;
`else
                    src_haz[i] = 1'b1;
`endif
                end else begin
                    src_haz[i] = 1'b1;
                end
            end
        end
        // A writeback to dst this cycle frees a slot, so a full counter may still accept.
        cap_haz = bus.FD_insn_writes
                  && (pend_q[bus.FD_insn_dst] == {PEND_W{1'b1}})
                  && !(wb && (bus.MW_insn_dst == bus.FD_insn_dst));
        dx_free = !dx_valid_q || bus.DX_ready;
        issue   = bus.FD_valid && !(|src_haz) && !cap_haz && dx_free;
        for (int i = 0; i < 3; i++) begin
            opnd[i] = bus.FD_src_used[i] ? src_data[i] : '0;
`ifdef DECODE_BYPASS_EN
            if (byp_sel[i]) begin
                opnd[i] = bus.W_result;
            end
`endif
        end
    end

    assign bus.FD_stall = bus.FD_valid && !issue;

    // D->X register next state: capture on issue, drain on accept, else hold.
    always_comb begin
        dx_valid_d  = dx_valid_q;
        dx_writes_d = dx_writes_q;
        dx_dst_d    = dx_dst_q;
        for (int i = 0; i < 3; i++) begin
            dx_src_d[i] = dx_src_q[i];
        end
        if (issue) begin
            dx_valid_d  = 1'b1;
            dx_writes_d = bus.FD_insn_writes;
            dx_dst_d    = bus.FD_insn_dst;
            for (int i = 0; i < 3; i++) begin
                dx_src_d[i] = opnd[i];
            end
        end else if (bus.DX_ready) begin
            dx_valid_d = 1'b0;
        end
    end

    // Scoreboard next state: +1 on issuing a write, -1 on a counted writeback.
    always_comb begin
        for (int r = 0; r < REG_CNT; r++) begin
            logic inc;
            logic dec;
            inc = issue && bus.FD_insn_writes && (bus.FD_insn_dst == PTR_W'(r));
            dec = wb && (bus.MW_insn_dst == PTR_W'(r)) && (pend_q[r] != '0);
            pend_d[r] = pend_q[r];
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + PEND_W'(1);
            end else if (dec && !inc) begin
                pend_d[r] = pend_q[r] - PEND_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_valid_q  <= 1'b0;
            dx_writes_q <= 1'b0;
            dx_dst_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                dx_src_q[i] <= '0;
            end
            for (int r = 0; r < REG_CNT; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            dx_valid_q  <= dx_valid_d;
            dx_writes_q <= dx_writes_d;
            dx_dst_q    <= dx_dst_d;
            for (int i = 0; i < 3; i++) begin
                dx_src_q[i] <= dx_src_d[i];
            end
            for (int r = 0; r < REG_CNT; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

    assign bus.DX_valid       = dx_valid_q;
    assign bus.DX_insn_writes = dx_writes_q;
    assign bus.DX_insn_dst    = dx_dst_q;
    assign bus.DX_src_0_data  = dx_src_q[0];
    assign bus.DX_src_1_data  = dx_src_q[1];
    assign bus.DX_src_2_data  = dx_src_q[2];

endmodule

// File: tb/tb_decode_operand_stage.sv
// Randomized bench for decode_operand_stage with a scoreboard: the driver
// keeps a count-of-outstanding-writes model and a register file, predicts
// stalls, and queues the expected DX contents; a monitor pops and compares
// whenever the DX register is handed to X.
module tb_decode_operand_stage;
    localparam int DATA_W  = 8;
    localparam int REG_CNT = 16;
    localparam int PTR_W   = 4;
    localparam int PEND_W  = 2;
    localparam int PEND_MAX = 3;

    typedef struct packed {
        logic [DATA_W-1:0] s0;
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
        logic [PTR_W-1:0]  dst;
        logic              wr;
    } dx_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_operand_stage_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

    decode_operand_stage #(
        .DATA_W(DATA_W), .REG_CNT(REG_CNT), .PTR_W(PTR_W), .PEND_W(PEND_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [DATA_W-1:0] rf [REG_CNT];
    assign bus.D_src_0_data = rf[bus.FD_insn_src_0];
    assign bus.D_src_1_data = rf[bus.FD_insn_src_1];
    assign bus.D_src_2_data = rf[bus.FD_insn_src_2];

    int  pend [REG_CNT];
    bit  m_dxv;
    dx_t exp_q [$];
    bit  rf_wr;
    logic [PTR_W-1:0]  rf_wa;
    logic [DATA_W-1:0] rf_wd;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DX hand-off must match the oldest predicted instruction.
    always @(negedge clk) begin
        if (!reset && bus.DX_valid === 1'b1 && bus.DX_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("dx_unexpected_output", 32'd1, 32'd0);
            end else begin
                dx_t e;
                e = exp_q.pop_front();
                check("dx_src_0_data", 32'(bus.DX_src_0_data), 32'(e.s0));
                check("dx_src_1_data", 32'(bus.DX_src_1_data), 32'(e.s1));
                check("dx_src_2_data", 32'(bus.DX_src_2_data), 32'(e.s2));
                check("dx_insn_dst", 32'(bus.DX_insn_dst), 32'(e.dst));
                check("dx_insn_writes", 32'(bus.DX_insn_writes), 32'(e.wr));
            end
        end
    end

    task automatic apply_rf_write();
        if (rf_wr) rf[rf_wa] = rf_wd;
        rf_wr = 1'b0;
    endtask

    // One clock of random stimulus plus prediction.
    task automatic drive_cycle(input int nreg, input int fd_pct, input int wb_pct,
                               input int rdy_pct, input int wr_pct);
        int cand [$];
        int k;
        logic [PTR_W-1:0] s [3];
        logic [DATA_W-1:0] op [3];
        bit wbv, haz, iss, cap, dec;
        dx_t e;
        @(posedge clk);
        #1;
        apply_rf_write();
        bus.FD_valid       = ($urandom_range(0, 99) < fd_pct);
        bus.FD_insn_src_0  = PTR_W'($urandom_range(0, nreg - 1));
        bus.FD_insn_src_1  = PTR_W'($urandom_range(0, nreg - 1));
        bus.FD_insn_src_2  = PTR_W'($urandom_range(0, nreg - 1));
        bus.FD_src_used    = 3'($urandom);
        bus.FD_insn_dst    = PTR_W'($urandom_range(0, nreg - 1));
        bus.FD_insn_writes = ($urandom_range(0, 99) < wr_pct);
        bus.W_result       = DATA_W'($urandom);
        bus.DX_ready       = ($urandom_range(0, 99) < rdy_pct);
        for (int r = 0; r < nreg; r++) if (pend[r] > 0) cand.push_back(r);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            bus.MW_insn_dst = PTR_W'(cand[$urandom_range(0, cand.size() - 1)]);
        else
            bus.MW_insn_dst = PTR_W'($urandom_range(0, nreg - 1));
        if ($urandom_range(0, 99) < wb_pct) begin
            k = $urandom_range(1, 3);
            bus.MW_insn_is_F1 = k[0];
            bus.MW_insn_is_F2 = k[1];
        end else begin
            bus.MW_insn_is_F1 = 1'b0;
            bus.MW_insn_is_F2 = 1'b0;
        end

        @(negedge clk);
        s[0] = bus.FD_insn_src_0;
        s[1] = bus.FD_insn_src_1;
        s[2] = bus.FD_insn_src_2;
        wbv  = bus.MW_insn_is_F1 | bus.MW_insn_is_F2;
        haz  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op[i] = '0;
            if (bus.FD_src_used[i]) begin
                op[i] = rf[s[i]];
                if (pend[s[i]] == 1 && wbv && bus.MW_insn_dst == s[i]) begin
`ifdef DECODE_BYPASS_EN
                    op[i] = bus.W_result;
`else
                    haz = 1'b1;
`endif
                end else if (pend[s[i]] > 0) begin
                    haz = 1'b1;
                end
            end
        end
        cap = bus.FD_insn_writes && pend[bus.FD_insn_dst] == PEND_MAX
              && !(wbv && bus.MW_insn_dst == bus.FD_insn_dst);
        iss = bus.FD_valid && !haz && !cap && (!m_dxv || bus.DX_ready);
        check("fd_stall", 32'(bus.FD_stall), 32'(bus.FD_valid && !iss));
        check("dx_valid", 32'(bus.DX_valid), 32'(m_dxv));
        if (iss) begin
            e.s0 = op[0]; e.s1 = op[1]; e.s2 = op[2];
            e.dst = bus.FD_insn_dst;
            e.wr  = bus.FD_insn_writes;
            exp_q.push_back(e);
        end
        m_dxv = iss ? 1'b1 : (bus.DX_ready ? 1'b0 : m_dxv);
        dec = wbv && pend[bus.MW_insn_dst] > 0;
        if (dec) pend[bus.MW_insn_dst]--;
        if (iss && bus.FD_insn_writes) pend[bus.FD_insn_dst]++;
        if (wbv) begin
            rf_wr = 1'b1;
            rf_wa = bus.MW_insn_dst;
            rf_wd = bus.W_result;
        end
    endtask

    task automatic idle_inputs();
        bus.FD_valid       = 1'b0;
        bus.FD_insn_src_0  = '0;
        bus.FD_insn_src_1  = '0;
        bus.FD_insn_src_2  = '0;
        bus.FD_src_used    = '0;
        bus.FD_insn_dst    = '0;
        bus.FD_insn_writes = 1'b0;
        bus.MW_insn_dst    = '0;
        bus.MW_insn_is_F1  = 1'b0;
        bus.MW_insn_is_F2  = 1'b0;
        bus.W_result       = '0;
        bus.DX_ready       = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dx_valid"}, 32'(bus.DX_valid), 32'd0);
        check({tag, "_dx_writes"}, 32'(bus.DX_insn_writes), 32'd0);
        check({tag, "_dx_dst"}, 32'(bus.DX_insn_dst), 32'd0);
        check({tag, "_dx_src0"}, 32'(bus.DX_src_0_data), 32'd0);
        check({tag, "_dx_src1"}, 32'(bus.DX_src_1_data), 32'd0);
        check({tag, "_dx_src2"}, 32'(bus.DX_src_2_data), 32'd0);
        check({tag, "_fd_stall"}, 32'(bus.FD_stall), 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle, with writes still in flight.
    task automatic mid_reset();
        @(posedge clk);
        #1;
        apply_rf_write();
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        for (int r = 0; r < REG_CNT; r++) pend[r] = 0;
        m_dxv = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int busy;
        reset = 1'b1;
        rf_wr = 1'b0;
        m_dxv = 1'b0;
        for (int r = 0; r < REG_CNT; r++) begin
            pend[r] = 0;
            rf[r]   = DATA_W'($urandom);
        end
        idle_inputs();
        #12;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Balanced traffic, then write-heavy with rare writebacks (capacity stalls),
        // then a back-pressured X stage, then a mid-stream reset and more traffic.
        for (int c = 0; c < 1200; c++) drive_cycle(6, 80, 60, 80, 50);
        for (int c = 0; c < 800; c++)  drive_cycle(3, 90, 15, 90, 90);
        for (int c = 0; c < 800; c++)  drive_cycle(6, 90, 50, 25, 50);
        busy = 0;
        for (int r = 0; r < REG_CNT; r++) busy += pend[r];
        if (busy == 0) begin
            for (int c = 0; c < 50 && busy == 0; c++) begin
                drive_cycle(3, 100, 0, 100, 100);
                busy = 0;
                for (int r = 0; r < REG_CNT; r++) busy += pend[r];
            end
        end
        mid_reset();
        for (int c = 0; c < 1200; c++) drive_cycle(8, 80, 60, 75, 50);
        for (int c = 0; c < 800; c++)  drive_cycle(2, 95, 40, 90, 70);

        for (int c = 0; c < 8; c++) drive_cycle(4, 0, 100, 100, 0);
        @(posedge clk);
        #1;
        apply_rf_write();
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
